// File: rtl/bcd_uart_reporter_pkg.sv
// rtl/bcd_uart_reporter_pkg.sv - shared ASCII constants, frame length, FSM encodings and byte mux
package bcd_uart_reporter_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_BYTES = 6;

  // LOAD and DONE are only ever visited combinationally; the register holds IDLE or SEND.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Digits above 9 are not valid BCD and are reported as '?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    if (d > 4'd9) return ASCII_Q;
    return ASCII_0 + {4'd0, d};
  endfunction

  // Byte idx of the frame "d3 d2 d1 d0 CR LF" built from a 4-digit snapshot.
  function automatic logic [7:0] frame_byte(input logic [15:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = digit_ascii(snap[15:12]);
      3'd1:    b = digit_ascii(snap[11:8]);
      3'd2:    b = digit_ascii(snap[7:4]);
      3'd3:    b = digit_ascii(snap[3:0]);
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bcd_uart_reporter_uart_tx_8n1.sv
// rtl/bcd_uart_reporter_uart_tx_8n1.sv - 8N1 UART byte transmitter with per-bit baud reload
module uart_tx_8n1 #(
  parameter int BAUD_RLD          = 867,
  parameter int BAUD_RLD_TURBOSIM = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turbosim,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  logic [9:0] shift;
  logic [3:0] bit_cnt;
  logic [9:0] baud_cnt;
  logic       active;
  logic [9:0] rld;

  // turbosim is looked at whenever a new bit begins, so a change lands on the next bit.
  assign rld  = turbosim ? 10'(BAUD_RLD_TURBOSIM) : 10'(BAUD_RLD);
  assign tx   = active ? shift[0] : 1'b1;
  assign busy = active;
  assign done = active && (baud_cnt == 10'd0) && (bit_cnt == 4'd9);

  // Shift out start, 8 data bits LSB first, stop; start may coincide with done for back-to-back bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift    <= 10'h3FF;
      bit_cnt  <= 4'd0;
      baud_cnt <= 10'd0;
      active   <= 1'b0;
    end else if (start) begin
      shift    <= {1'b1, data, 1'b0};
      bit_cnt  <= 4'd0;
      baud_cnt <= rld;
      active   <= 1'b1;
    end else if (active) begin
      if (baud_cnt == 10'd0) begin
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt  <= bit_cnt + 4'd1;
          shift    <= {1'b1, shift[9:1]};
          baud_cnt <= rld;
        end
      end else begin
        baud_cnt <= baud_cnt - 10'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_uart_reporter.sv
// rtl/bcd_uart_reporter.sv - snapshots BCD reaction time on result-state entry and sends it as ASCII over UART
module bcd_uart_reporter
  import bcd_uart_reporter_pkg::*;
#(
  parameter int         BAUD_RLD          = 867,
  parameter int         BAUD_RLD_TURBOSIM = 7,
  parameter logic [3:0] REPORT_STATE      = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        turbosim,
  input  logic        en,
  input  logic [15:0] bcd,
  input  logic [3:0]  fsm_state,
  output logic        tx,
  output logic        busy,
  output logic        pending,
  output logic [7:0]  frames_sent
);

  logic [3:0]  prev_state;
  logic [1:0]  state, state_n, st;
  logic [2:0]  idx, idx_n;
  logic [15:0] snapshot, snapshot_n;
  logic [15:0] pend_snap, pend_snap_n;
  logic        pending_n;
  logic [7:0]  frames_n;
  logic        trig, trig_taken;
  logic        tx_start, tx_done;
  logic [7:0]  tx_data;

  assign trig = en && (fsm_state == REPORT_STATE) && (prev_state != REPORT_STATE);

  // Walk SEND -> LOAD/DONE -> LOAD/IDLE within one cycle so bytes and frames abut with no gap.
  always_comb begin
    st          = state;
    idx_n       = idx;
    snapshot_n  = snapshot;
    pend_snap_n = pend_snap;
    pending_n   = pending;
    frames_n    = frames_sent;
    trig_taken  = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;

    if (state == ST_SEND && tx_done) begin
      if (idx < 3'(FRAME_BYTES - 1)) begin
        idx_n = idx + 3'd1;
        st    = ST_LOAD;
      end else begin
        st       = ST_DONE;
        frames_n = frames_sent + 8'd1;
      end
    end

    if (st == ST_DONE) begin
      if (pending) begin
        snapshot_n = pend_snap;
        pending_n  = 1'b0;
        idx_n      = 3'd0;
        st         = ST_LOAD;
      end else if (trig) begin
        snapshot_n = bcd;
        trig_taken = 1'b1;
        idx_n      = 3'd0;
        st         = ST_LOAD;
      end else begin
        st = ST_IDLE;
      end
    end else if (st == ST_IDLE && trig) begin
      snapshot_n = bcd;
      trig_taken = 1'b1;
      idx_n      = 3'd0;
      st         = ST_LOAD;
    end

    // A trigger that cannot start a frame now is queued; later ones overwrite it.
    if (trig && !trig_taken) begin
      pend_snap_n = bcd;
      pending_n   = 1'b1;
    end

    if (st == ST_LOAD) begin
      tx_start = 1'b1;
      tx_data  = frame_byte(snapshot_n, idx_n);
      st       = ST_SEND;
    end

    state_n = st;
  end

  // Register FSM, snapshots, edge-detect history and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      snapshot    <= 16'h0000;
      pend_snap   <= 16'h0000;
      pending     <= 1'b0;
      frames_sent <= 8'd0;
      prev_state  <= 4'd0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      snapshot    <= snapshot_n;
      pend_snap   <= pend_snap_n;
      pending     <= pending_n;
      frames_sent <= frames_n;
      prev_state  <= fsm_state;
    end
  end

  uart_tx_8n1 #(
    .BAUD_RLD          (BAUD_RLD),
    .BAUD_RLD_TURBOSIM (BAUD_RLD_TURBOSIM)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .turbosim (turbosim),
    .start    (tx_start),
    .data     (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (tx_done)
  );

endmodule
